// File: rtl/xm_bus_pkg.sv
// Shared bus constants and state type for the CPU memory-port Wishbone slave.
package xm_bus_pkg;

  localparam int BUS_WORD  = 16;
  localparam int BUS_ADR_W = BUS_WORD - (BUS_WORD / 8) + 1;
  localparam int BUS_LANES = BUS_WORD / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } wb_slv_state_t;

endpackage

// File: rtl/xm_sram_bytewr.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
module xm_sram_bytewr #(
  parameter int DW = 16,
  parameter int AW = 10
) (
  input  logic            clk_i,
  input  logic            en_i,
  input  logic            we_i,
  input  logic [DW/8-1:0] be_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [DW-1:0]   wdata_i,
  output logic [DW-1:0]   rdata_o
);

  localparam int unsigned LANES = DW / 8;

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // Read register only moves on reads, so a byte-masked write never disturbs it.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int unsigned b = 0; b < LANES; b++) begin
          if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/xm_wb_sram_slave.sv
// Wishbone-classic slave serving the CPU memory port from on-chip SRAM with a
// programmable ack latency and out-of-window error flagging.
module xm_wb_sram_slave
  import xm_bus_pkg::*;
#(
  parameter int WORD        = BUS_WORD,
  parameter int ADR_W       = BUS_ADR_W,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cyc_i,
  input  logic              stb_i,
  input  logic              we_i,
  input  logic [WORD/8-1:0] sel_i,
  input  logic [ADR_W-1:0]  adr_i,
  input  logic [WORD-1:0]   dat_i,
  output logic              ack_o,
  output logic [WORD-1:0]   dat_o,
  output logic              rangeErr_o
);

  localparam int         LANES = WORD / 8;
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  wb_slv_state_t    state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [ADR_W-1:0] adr_q;
  logic [WORD-1:0]  dat_q;
  logic [LANES-1:0] sel_q;
  logic             we_q;
  logic             rd_zero_q, rd_zero_d;

  logic             req, enter_ack;
  logic [ADR_W-1:0] acc_adr;
  logic [WORD-1:0]  acc_dat;
  logic [LANES-1:0] acc_sel;
  logic             acc_we, acc_oor;
  logic             ram_en;
  logic [WORD-1:0]  ram_rdata;

  assign req = cyc_i & stb_i;

  // With zero wait states the access happens on the sampling edge itself,
  // so the live bus feeds the RAM in IDLE and the latched copy otherwise.
  always_comb begin
    if (state_q == IDLE) begin
      acc_adr = adr_i;
      acc_dat = dat_i;
      acc_sel = sel_i;
      acc_we  = we_i;
    end else begin
      acc_adr = adr_q;
      acc_dat = dat_q;
      acc_sel = sel_q;
      acc_we  = we_q;
    end
  end

  assign acc_oor = |acc_adr[ADR_W-1:DEPTH_LOG2];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_zero_d = rd_zero_q;
    enter_ack = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d = WS;
          if (WS == 4'd0) begin
            state_d   = ACK;
            enter_ack = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (!cyc_i) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd1) begin
          state_d   = ACK;
          enter_ack = 1'b1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (enter_ack && !acc_we) rd_zero_d = acc_oor;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_zero_q <= 1'b1;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_zero_q <= rd_zero_d;
      if (state_q == IDLE && req) begin
        adr_q <= adr_i;
        dat_q <= dat_i;
        sel_q <= sel_i;
        we_q  <= we_i;
      end
    end
  end

  assign ram_en = enter_ack & ~acc_oor & ~rst_i;

  xm_sram_bytewr #(
    .DW (WORD),
    .AW (DEPTH_LOG2)
  ) u_sram (
    .clk_i   (clk_i),
    .en_i    (ram_en),
    .we_i    (acc_we),
    .be_i    (acc_sel),
    .addr_i  (acc_adr[DEPTH_LOG2-1:0]),
    .wdata_i (acc_dat),
    .rdata_o (ram_rdata)
  );

  assign ack_o      = (state_q == ACK);
  assign rangeErr_o = (state_q == ACK) & (|adr_q[ADR_W-1:DEPTH_LOG2]);
  assign dat_o      = rd_zero_q ? '0 : ram_rdata;

endmodule

// File: tb/tb_xm_wb_sram_slave.sv
// Bench for xm_wb_sram_slave: three instances (0, 1 and 3 wait states) checked
// every cycle against a transaction-level memory model plus literal pins.
module tb_xm_wb_sram_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [1:0]  sel = '0;
  logic [14:0] adr = '0;
  logic [15:0] dat = '0;
  int          dsel = 0;

  logic [2:0]  cyc_v;
  logic [2:0]  ack_v, rerr_v;
  logic [15:0] dat_v [3];

  always #5 clk = ~clk;

  assign cyc_v[0] = cyc && dsel == 0;
  assign cyc_v[1] = cyc && dsel == 1;
  assign cyc_v[2] = cyc && dsel == 2;

  xm_wb_sram_slave #(.WORD(16), .ADR_W(15), .DEPTH_LOG2(10), .WAIT_STATES(1)) u_ws1 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc_v[0]), .stb_i(stb && dsel == 0), .we_i(we),
    .sel_i(sel), .adr_i(adr), .dat_i(dat),
    .ack_o(ack_v[0]), .dat_o(dat_v[0]), .rangeErr_o(rerr_v[0]));

  xm_wb_sram_slave #(.WORD(16), .ADR_W(15), .DEPTH_LOG2(10), .WAIT_STATES(3)) u_ws3 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc_v[1]), .stb_i(stb && dsel == 1), .we_i(we),
    .sel_i(sel), .adr_i(adr), .dat_i(dat),
    .ack_o(ack_v[1]), .dat_o(dat_v[1]), .rangeErr_o(rerr_v[1]));

  xm_wb_sram_slave #(.WORD(16), .ADR_W(15), .DEPTH_LOG2(10), .WAIT_STATES(0)) u_ws0 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc_v[2]), .stb_i(stb && dsel == 2), .we_i(we),
    .sel_i(sel), .adr_i(adr), .dat_i(dat),
    .ack_o(ack_v[2]), .dat_o(dat_v[2]), .rangeErr_o(rerr_v[2]));

  int WS_OF [3] = '{1, 3, 0};

  int edge_cnt = 0;
  logic rst_seen = 1'b1;
  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    rst_seen <= rst;
  end

  // Outstanding request as the master issued it (written by the stimulus only).
  bit          pend_valid = 1'b0;
  int          pend_dut = 0, pend_n = -100, pend_lat = 0, pend_lit = -1;
  bit          pend_we = 1'b0, pend_lrerr = 1'b0;
  logic [14:0] pend_adr = '0;
  logic [15:0] pend_dat = '0;
  logic [1:0]  pend_sel = '0;
  bit          chk_en = 1'b0, done = 1'b0;
  int          timeouts = 0;

  // Model state and counters (written by the compare process only).
  logic [15:0] model_mem [3][1024];
  logic [15:0] exp_dat [3];
  int          n_checks = 0, n_errors = 0, pinned_n = -1;
  bit          fire;
  logic [15:0] mask;

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s @edge %0d: got %h, expected %h", nm, edge_cnt, got, expv);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (rst_seen) for (int d = 0; d < 3; d++) exp_dat[d] = '0;
      fire = pend_valid && (edge_cnt == pend_n + WS_OF[pend_dut]);
      if (fire) begin
        if (pend_adr < 15'd1024) begin
          if (pend_we) begin
            mask = {{8{pend_sel[1]}}, {8{pend_sel[0]}}};
            model_mem[pend_dut][pend_adr[9:0]] =
              (model_mem[pend_dut][pend_adr[9:0]] & ~mask) | (pend_dat & mask);
          end else begin
            exp_dat[pend_dut] = model_mem[pend_dut][pend_adr[9:0]];
          end
        end else if (!pend_we) begin
          exp_dat[pend_dut] = '0;
        end
      end
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("ack[%0d]", d), 16'(ack_v[d]), 16'(fire && pend_dut == d));
        chk($sformatf("rangeErr[%0d]", d), 16'(rerr_v[d]),
            16'(fire && pend_dut == d && pend_adr >= 15'd1024));
        chk($sformatf("dat[%0d]", d), dat_v[d], exp_dat[d]);
      end
      if (pend_valid && ack_v[pend_dut] === 1'b1 && pend_n != pinned_n) begin
        pinned_n = pend_n;
        chk($sformatf("pin latency adr %h", pend_adr), 16'(edge_cnt - pend_n), 16'(pend_lat));
        if (pend_lit >= 0)
          chk($sformatf("pin rdata adr %h", pend_adr), dat_v[pend_dut], pend_lit[15:0]);
        chk($sformatf("pin rangeErr adr %h", pend_adr), 16'(rerr_v[pend_dut]), 16'(pend_lrerr));
      end
    end
    if (done) begin
      chk("bounded ack waits", 16'(timeouts), 16'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
    end
  end

  task automatic start(input int d, input bit w, input logic [14:0] a, input logic [15:0] wd,
                       input logic [1:0] s, input int lat, input int lit, input bit lrerr);
    dsel = d; cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = wd; sel = s;
    pend_dut = d; pend_we = w; pend_adr = a; pend_dat = wd; pend_sel = s;
    pend_n = edge_cnt + 1; pend_lat = lat; pend_lit = lit; pend_lrerr = lrerr;
    pend_valid = 1'b1;
  endtask

  // Called #1 after an edge; returns #1 after the edge that ends the ack cycle.
  task automatic xfer(input int d, input bit w, input logic [14:0] a, input logic [15:0] wd,
                      input logic [1:0] s, input int lat, input int lit, input bit lrerr,
                      input bit scr, input bit hold);
    bit seen = 1'b0;
    start(d, w, a, wd, s, lat, lit, lrerr);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (scr && edge_cnt == pend_n) begin adr = ~a; dat = ~wd; sel = ~s; end
      seen = (ack_v[d] === 1'b1);
    end
    if (!seen) timeouts++;
    @(posedge clk); #1;
    if (!hold) begin
      cyc = 1'b0; stb = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic wr(input int d, input logic [14:0] a, input logic [15:0] wd, input logic [1:0] s,
                    input bit lrerr);
    xfer(d, 1'b1, a, wd, s, WS_OF[d], -1, lrerr, 1'b0, 1'b0);
  endtask

  task automatic rd(input int d, input logic [14:0] a, input int lit, input bit lrerr);
    xfer(d, 1'b0, a, 16'h0, 2'b11, WS_OF[d], lit, lrerr, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // One wait state: latency, byte lanes, out-of-window behaviour
    wr(0, 15'h0000, 16'hC3C3, 2'b11, 1'b0);
    xfer(0, 1'b1, 15'h0010, 16'hBEEF, 2'b11, 1, -1, 1'b0, 1'b0, 1'b0);
    rd(0, 15'h0010, 32'hBEEF, 1'b0);
    wr(0, 15'h0010, 16'h1234, 2'b01, 1'b0);
    rd(0, 15'h0010, 32'hBE34, 1'b0);
    wr(0, 15'h0010, 16'h5600, 2'b10, 1'b0);
    rd(0, 15'h0010, 32'h5634, 1'b0);
    wr(0, 15'h0010, 16'hFFFF, 2'b00, 1'b0);
    rd(0, 15'h0010, 32'h5634, 1'b0);
    wr(0, 15'h0400, 16'hAAAA, 2'b11, 1'b1);
    rd(0, 15'h0400, 32'h0000, 1'b1);
    rd(0, 15'h0000, 32'hC3C3, 1'b0);
    wr(0, 15'h4010, 16'h9999, 2'b11, 1'b1);
    rd(0, 15'h0010, 32'h5634, 1'b0);

    // Three wait states: abort, reset mid-wait, inputs changing during wait
    xfer(1, 1'b1, 15'h0020, 16'h0000, 2'b11, 3, -1, 1'b0, 1'b0, 1'b0);
    start(1, 1'b1, 15'h0020, 16'h1111, 2'b11, 3, -1, 1'b0);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; pend_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rd(1, 15'h0020, 32'h0000, 1'b0);
    rd(0, 15'h0010, 32'h5634, 1'b0);
    start(1, 1'b1, 15'h0020, 16'h2222, 2'b11, 3, -1, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; pend_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rd(1, 15'h0020, 32'h0000, 1'b0);
    xfer(1, 1'b1, 15'h0030, 16'h7777, 2'b11, 3, -1, 1'b0, 1'b1, 1'b0);
    rd(1, 15'h0030, 32'h7777, 1'b0);

    // Zero wait states: back-to-back write then read with stb held
    xfer(2, 1'b1, 15'h0001, 16'h0001, 2'b11, 0, -1, 1'b0, 1'b0, 1'b1);
    xfer(2, 1'b0, 15'h0001, 16'h0000, 2'b11, 0, 32'h0001, 1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1 done = 1'b1;
  end

endmodule
